// File: rtl/obi_instr_arbiter.sv
// Shares one OBI instruction port between NUM_REQ requesters and routes responses back in order.
// Define OBI_ARB_FIXED_PRIO_EN for fixed priority (lowest index wins) instead of round-robin.
module obi_instr_arbiter #(
    parameter int unsigned NUM_REQ         = 2,
    parameter int unsigned MAX_OUTSTANDING = 2,
    parameter int unsigned ADDR_W          = 32,
    parameter int unsigned DATA_W          = 32
) (
    input  logic                                 clk_i,
    input  logic                                 rst_ni,
    input  logic [NUM_REQ-1:0]                   req_i,
    input  logic [NUM_REQ*ADDR_W-1:0]            addr_i,
    output logic [NUM_REQ-1:0]                   gnt_o,
    output logic [NUM_REQ-1:0]                   rvalid_o,
    output logic [DATA_W-1:0]                    rdata_o,
    output logic                                 mem_req_o,
    output logic [ADDR_W-1:0]                    mem_addr_o,
    input  logic                                 mem_gnt_i,
    input  logic                                 mem_rvalid_i,
    input  logic [DATA_W-1:0]                    mem_rdata_i,
    output logic [$clog2(MAX_OUTSTANDING+1)-1:0] outstanding_o,
    output logic                                 proto_err_o
);

    localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned CNT_W = $clog2(MAX_OUTSTANDING + 1);
    localparam int unsigned PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;

    typedef enum logic {
        IDLE,
        LOCKED
    } state_e;

    state_e           state_q, state_d;
    logic [IDX_W-1:0] lock_idx_q, lock_idx_d;
    logic [IDX_W-1:0] winner;
    logic [IDX_W-1:0] cand;
    logic [IDX_W-1:0] sel;
    logic             any_req;
    logic             cap_reached;
    logic             push;
    logic             pop;
    logic [CNT_W-1:0] cnt_q;
    logic [PTR_W-1:0] rd_ptr_q, wr_ptr_q;
    logic [IDX_W-1:0] fifo_q [MAX_OUTSTANDING];
    logic [IDX_W-1:0] head_id;
    logic             proto_err_q;
`ifndef OBI_ARB_FIXED_PRIO_EN
    logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
`endif

    always_comb begin
        any_req = 1'b0;
        winner  = '0;
        cand    = '0;
`ifdef OBI_ARB_FIXED_PRIO_EN
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            cand = IDX_W'(i);
            if (req_i[cand]) begin
                any_req = 1'b1;
                winner  = cand;
            end
        end
`else
        // Search upward from the pointer, wrapping; the first requester found wins.
        for (int i = 0; i < NUM_REQ; i++) begin
            cand = IDX_W'((int'(rr_ptr_q) + i) % NUM_REQ);
            if (!any_req && req_i[cand]) begin
                any_req = 1'b1;
                winner  = cand;
            end
        end
`endif
    end

    always_comb begin
        state_d     = state_q;
        lock_idx_d  = lock_idx_q;
        sel         = winner;
        mem_req_o   = 1'b0;
        mem_addr_o  = '0;
        gnt_o       = '0;
        push        = 1'b0;
`ifndef OBI_ARB_FIXED_PRIO_EN
        rr_ptr_d    = rr_ptr_q;
`endif
        cap_reached = (cnt_q == CNT_W'(MAX_OUTSTANDING));

        // A lock only exists with a free slot, so LOCKED never needs the cap check.
        if (state_q == LOCKED) begin
            sel       = lock_idx_q;
            mem_req_o = 1'b1;
        end else begin
            mem_req_o = any_req && (!cap_reached || mem_rvalid_i);
        end

        if (mem_req_o) begin
            for (int k = 0; k < NUM_REQ; k++) begin
                if (sel == IDX_W'(k)) begin
                    mem_addr_o = addr_i[k*ADDR_W +: ADDR_W];
                end
            end
            if (mem_gnt_i) begin
                gnt_o[sel] = 1'b1;
                push       = 1'b1;
                state_d    = IDLE;
`ifndef OBI_ARB_FIXED_PRIO_EN
                rr_ptr_d   = (sel == IDX_W'(NUM_REQ - 1)) ? '0 : sel + 1'b1;
`endif
            end else begin
                state_d    = LOCKED;
                lock_idx_d = sel;
            end
        end
    end

    assign pop      = mem_rvalid_i && (cnt_q != '0);
    assign head_id  = fifo_q[rd_ptr_q];

    always_comb begin
        rvalid_o = '0;
        if (pop) begin
            rvalid_o[head_id] = 1'b1;
        end
    end

    assign rdata_o       = pop ? mem_rdata_i : '0;
    assign outstanding_o = cnt_q;
    assign proto_err_o   = proto_err_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= IDLE;
            lock_idx_q <= '0;
`ifndef OBI_ARB_FIXED_PRIO_EN
            rr_ptr_q   <= '0;
`endif
        end else begin
            state_q    <= state_d;
            lock_idx_q <= lock_idx_d;
`ifndef OBI_ARB_FIXED_PRIO_EN
            rr_ptr_q   <= rr_ptr_d;
`endif
        end
    end

    // The ID FIFO occupancy is the outstanding count; a response into an empty FIFO is an error.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q       <= '0;
            rd_ptr_q    <= '0;
            wr_ptr_q    <= '0;
            proto_err_q <= 1'b0;
            for (int i = 0; i < MAX_OUTSTANDING; i++) begin
                fifo_q[i] <= '0;
            end
        end else begin
            if (push) begin
                fifo_q[wr_ptr_q] <= sel;
                wr_ptr_q <= (wr_ptr_q == PTR_W'(MAX_OUTSTANDING - 1)) ? '0 : wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= (rd_ptr_q == PTR_W'(MAX_OUTSTANDING - 1)) ? '0 : rd_ptr_q + 1'b1;
            end
            if (push && !pop && (cnt_q != CNT_W'(MAX_OUTSTANDING))) begin
                cnt_q <= cnt_q + 1'b1;
            end else if (pop && !push) begin
                cnt_q <= cnt_q - 1'b1;
            end
            if (mem_rvalid_i && (cnt_q == '0)) begin
                proto_err_q <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_obi_instr_arbiter.sv
// Directed self-checking bench for obi_instr_arbiter (NUM_REQ=2, MAX_OUTSTANDING=2).
module tb_obi_instr_arbiter;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic [1:0]  req_i;
    logic [63:0] addr_i;
    logic [1:0]  gnt_o;
    logic [1:0]  rvalid_o;
    logic [31:0] rdata_o;
    logic        mem_req_o;
    logic [31:0] mem_addr_o;
    logic        mem_gnt_i;
    logic        mem_rvalid_i;
    logic [31:0] mem_rdata_i;
    logic [1:0]  outstanding_o;
    logic        proto_err_o;

    int checks   = 0;
    int failures = 0;

    obi_instr_arbiter #(
        .NUM_REQ(2),
        .MAX_OUTSTANDING(2),
        .ADDR_W(32),
        .DATA_W(32)
    ) dut (
        .clk_i(clk_i),
        .rst_ni(rst_ni),
        .req_i(req_i),
        .addr_i(addr_i),
        .gnt_o(gnt_o),
        .rvalid_o(rvalid_o),
        .rdata_o(rdata_o),
        .mem_req_o(mem_req_o),
        .mem_addr_o(mem_addr_o),
        .mem_gnt_i(mem_gnt_i),
        .mem_rvalid_i(mem_rvalid_i),
        .mem_rdata_i(mem_rdata_i),
        .outstanding_o(outstanding_o),
        .proto_err_o(proto_err_o)
    );

    always #5 clk_i = ~clk_i;

    // Inputs change on the falling edge; outputs are sampled 1 time unit later.
    task automatic set_inputs(input logic [1:0] req, input logic [31:0] a0, input logic [31:0] a1,
                              input logic gnt, input logic rv, input logic [31:0] rd);
        @(negedge clk_i);
        req_i        = req;
        addr_i       = {a1, a0};
        mem_gnt_i    = gnt;
        mem_rvalid_i = rv;
        mem_rdata_i  = rd;
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk_i);
        rst_ni       = 1'b0;
        req_i        = '0;
        addr_i       = '0;
        mem_gnt_i    = 1'b0;
        mem_rvalid_i = 1'b0;
        mem_rdata_i  = '0;
        repeat (2) @(negedge clk_i);
        rst_ni = 1'b1;
    endtask

    task automatic test_reset();
        @(negedge clk_i);
        rst_ni       = 1'b0;
        req_i        = '0;
        addr_i       = '0;
        mem_gnt_i    = 1'b0;
        mem_rvalid_i = 1'b0;
        mem_rdata_i  = '0;
        #1;
        checks++; if (mem_req_o !== 1'b0) begin failures++; $display("[TB] FAIL reset_mem_req: got %b expected 0", mem_req_o); end
        checks++; if (outstanding_o !== 2'd0) begin failures++; $display("[TB] FAIL reset_outstanding: got %0d expected 0", outstanding_o); end
        checks++; if (proto_err_o !== 1'b0) begin failures++; $display("[TB] FAIL reset_proto_err: got %b expected 0", proto_err_o); end
        repeat (2) @(negedge clk_i);
        rst_ni = 1'b1;
        set_inputs(2'b00, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0);
        checks++; if (gnt_o !== 2'b00 || rvalid_o !== 2'b00) begin failures++; $display("[TB] FAIL reset_gnt_rvalid: got %b/%b expected 00/00", gnt_o, rvalid_o); end
        checks++; if (rdata_o !== 32'h0 || mem_addr_o !== 32'h0) begin failures++; $display("[TB] FAIL reset_data_addr: got %h/%h expected 0/0", rdata_o, mem_addr_o); end
    endtask

    task automatic test_single();
        do_reset();
        set_inputs(2'b01, 32'h100, 32'h0, 1'b1, 1'b0, 32'h0);
        checks++; if (gnt_o !== 2'b01) begin failures++; $display("[TB] FAIL single_gnt: got %b expected 01", gnt_o); end
        checks++; if (mem_req_o !== 1'b1 || mem_addr_o !== 32'h100) begin failures++; $display("[TB] FAIL single_addr: got %b/%h expected 1/100", mem_req_o, mem_addr_o); end
        checks++; if (outstanding_o !== 2'd0) begin failures++; $display("[TB] FAIL single_cnt0: got %0d expected 0", outstanding_o); end
        set_inputs(2'b00, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0);
        checks++; if (outstanding_o !== 2'd1) begin failures++; $display("[TB] FAIL single_cnt1: got %0d expected 1", outstanding_o); end
        checks++; if (mem_req_o !== 1'b0) begin failures++; $display("[TB] FAIL single_req_idle: got %b expected 0", mem_req_o); end
        set_inputs(2'b00, 32'h0, 32'h0, 1'b0, 1'b1, 32'hDEADBEEF);
        checks++; if (rvalid_o !== 2'b01 || rdata_o !== 32'hDEADBEEF) begin failures++; $display("[TB] FAIL single_resp: got %b/%h expected 01/deadbeef", rvalid_o, rdata_o); end
        set_inputs(2'b00, 32'h0, 32'h0, 1'b0, 1'b0, 32'h12345678);
        checks++; if (outstanding_o !== 2'd0) begin failures++; $display("[TB] FAIL single_cnt_end: got %0d expected 0", outstanding_o); end
        checks++; if (rvalid_o !== 2'b00 || rdata_o !== 32'h0) begin failures++; $display("[TB] FAIL single_rdata_gate: got %b/%h expected 00/0", rvalid_o, rdata_o); end
    endtask

    task automatic test_round_robin();
        logic [1:0]  exp_gnt [4];
        logic [1:0]  exp_rv  [4];
        logic [1:0]  exp_last;
        logic [31:0] exp_addr;
`ifdef OBI_ARB_FIXED_PRIO_EN
        exp_gnt  = '{2'b01, 2'b01, 2'b01, 2'b01};
        exp_rv   = '{2'b00, 2'b01, 2'b01, 2'b01};
        exp_last = 2'b01;
`else
        exp_gnt  = '{2'b01, 2'b10, 2'b01, 2'b10};
        exp_rv   = '{2'b00, 2'b01, 2'b10, 2'b01};
        exp_last = 2'b10;
`endif
        do_reset();
        for (int i = 0; i < 4; i++) begin
            set_inputs(2'b11, 32'h400, 32'h500, 1'b1, (i != 0), 32'h1000 + i);
            exp_addr = (exp_gnt[i] == 2'b01) ? 32'h400 : 32'h500;
            checks++; if (gnt_o !== exp_gnt[i]) begin failures++; $display("[TB] FAIL rr_gnt[%0d]: got %b expected %b", i, gnt_o, exp_gnt[i]); end
            checks++; if (mem_addr_o !== exp_addr) begin failures++; $display("[TB] FAIL rr_addr[%0d]: got %h expected %h", i, mem_addr_o, exp_addr); end
            checks++; if (rvalid_o !== exp_rv[i]) begin failures++; $display("[TB] FAIL rr_rvalid[%0d]: got %b expected %b", i, rvalid_o, exp_rv[i]); end
        end
        set_inputs(2'b00, 32'h0, 32'h0, 1'b0, 1'b1, 32'h2000);
        checks++; if (rvalid_o !== exp_last || rdata_o !== 32'h2000) begin failures++; $display("[TB] FAIL rr_drain: got %b/%h expected %b/2000", rvalid_o, rdata_o, exp_last); end
        set_inputs(2'b00, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0);
        checks++; if (outstanding_o !== 2'd0) begin failures++; $display("[TB] FAIL rr_cnt_end: got %0d expected 0", outstanding_o); end
    endtask

    task automatic test_addr_lock();
        do_reset();
        set_inputs(2'b01, 32'h200, 32'h0, 1'b0, 1'b0, 32'h0);
        checks++; if (mem_req_o !== 1'b1 || mem_addr_o !== 32'h200 || gnt_o !== 2'b00) begin failures++; $display("[TB] FAIL lock_c0: got %b/%h/%b expected 1/200/00", mem_req_o, mem_addr_o, gnt_o); end
        set_inputs(2'b11, 32'h200, 32'h300, 1'b0, 1'b0, 32'h0);
        checks++; if (mem_addr_o !== 32'h200 || gnt_o !== 2'b00) begin failures++; $display("[TB] FAIL lock_c1: got %h/%b expected 200/00", mem_addr_o, gnt_o); end
        set_inputs(2'b10, 32'h200, 32'h300, 1'b0, 1'b0, 32'h0);
        checks++; if (mem_req_o !== 1'b1 || mem_addr_o !== 32'h200) begin failures++; $display("[TB] FAIL lock_req_drop: got %b/%h expected 1/200", mem_req_o, mem_addr_o); end
        set_inputs(2'b11, 32'h200, 32'h300, 1'b1, 1'b0, 32'h0);
        checks++; if (gnt_o !== 2'b01 || mem_addr_o !== 32'h200) begin failures++; $display("[TB] FAIL lock_release: got %b/%h expected 01/200", gnt_o, mem_addr_o); end
        set_inputs(2'b10, 32'h0, 32'h300, 1'b1, 1'b0, 32'h0);
        checks++; if (gnt_o !== 2'b10 || mem_addr_o !== 32'h300) begin failures++; $display("[TB] FAIL lock_next: got %b/%h expected 10/300", gnt_o, mem_addr_o); end
        checks++; if (outstanding_o !== 2'd1) begin failures++; $display("[TB] FAIL lock_cnt: got %0d expected 1", outstanding_o); end
        set_inputs(2'b00, 32'h0, 32'h0, 1'b0, 1'b1, 32'h11);
        checks++; if (rvalid_o !== 2'b01) begin failures++; $display("[TB] FAIL lock_resp0: got %b expected 01", rvalid_o); end
        set_inputs(2'b00, 32'h0, 32'h0, 1'b0, 1'b1, 32'h22);
        checks++; if (rvalid_o !== 2'b10) begin failures++; $display("[TB] FAIL lock_resp1: got %b expected 10", rvalid_o); end
    endtask

    task automatic test_outstanding_cap();
        do_reset();
        set_inputs(2'b01, 32'h10, 32'h20, 1'b1, 1'b0, 32'h0);
        set_inputs(2'b10, 32'h10, 32'h20, 1'b1, 1'b0, 32'h0);
        checks++; if (gnt_o !== 2'b10 || outstanding_o !== 2'd1) begin failures++; $display("[TB] FAIL cap_second: got %b/%0d expected 10/1", gnt_o, outstanding_o); end
        set_inputs(2'b01, 32'h10, 32'h20, 1'b1, 1'b0, 32'h0);
        checks++; if (mem_req_o !== 1'b0 || gnt_o !== 2'b00) begin failures++; $display("[TB] FAIL cap_block: got %b/%b expected 0/00", mem_req_o, gnt_o); end
        checks++; if (outstanding_o !== 2'd2) begin failures++; $display("[TB] FAIL cap_cnt: got %0d expected 2", outstanding_o); end
        set_inputs(2'b01, 32'h10, 32'h20, 1'b1, 1'b1, 32'h55);
        checks++; if (mem_req_o !== 1'b1 || gnt_o !== 2'b01 || rvalid_o !== 2'b01) begin failures++; $display("[TB] FAIL cap_swap: got %b/%b/%b expected 1/01/01", mem_req_o, gnt_o, rvalid_o); end
        set_inputs(2'b00, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0);
        checks++; if (outstanding_o !== 2'd2) begin failures++; $display("[TB] FAIL cap_cnt_hold: got %0d expected 2", outstanding_o); end
        set_inputs(2'b00, 32'h0, 32'h0, 1'b0, 1'b1, 32'h66);
        checks++; if (rvalid_o !== 2'b10) begin failures++; $display("[TB] FAIL cap_drain1: got %b expected 10", rvalid_o); end
        set_inputs(2'b00, 32'h0, 32'h0, 1'b0, 1'b1, 32'h77);
        checks++; if (rvalid_o !== 2'b01) begin failures++; $display("[TB] FAIL cap_drain2: got %b expected 01", rvalid_o); end
        set_inputs(2'b00, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0);
        checks++; if (outstanding_o !== 2'd0 || proto_err_o !== 1'b0) begin failures++; $display("[TB] FAIL cap_end: got %0d/%b expected 0/0", outstanding_o, proto_err_o); end
    endtask

    task automatic test_out_of_order_ids();
        do_reset();
        set_inputs(2'b10, 32'h0, 32'h80, 1'b1, 1'b0, 32'h0);
        checks++; if (gnt_o !== 2'b10) begin failures++; $display("[TB] FAIL ooo_gnt1: got %b expected 10", gnt_o); end
        set_inputs(2'b01, 32'h40, 32'h0, 1'b1, 1'b0, 32'h0);
        checks++; if (gnt_o !== 2'b01) begin failures++; $display("[TB] FAIL ooo_gnt0: got %b expected 01", gnt_o); end
        set_inputs(2'b00, 32'h0, 32'h0, 1'b0, 1'b1, 32'hA);
        checks++; if (rvalid_o !== 2'b10 || rdata_o !== 32'hA) begin failures++; $display("[TB] FAIL ooo_resp_a: got %b/%h expected 10/a", rvalid_o, rdata_o); end
        set_inputs(2'b00, 32'h0, 32'h0, 1'b0, 1'b1, 32'hB);
        checks++; if (rvalid_o !== 2'b01 || rdata_o !== 32'hB) begin failures++; $display("[TB] FAIL ooo_resp_b: got %b/%h expected 01/b", rvalid_o, rdata_o); end
    endtask

    task automatic test_spurious_and_reset();
        do_reset();
        set_inputs(2'b00, 32'h0, 32'h0, 1'b0, 1'b1, 32'hBAD);
        checks++; if (rvalid_o !== 2'b00 || rdata_o !== 32'h0) begin failures++; $display("[TB] FAIL spur_drop: got %b/%h expected 00/0", rvalid_o, rdata_o); end
        set_inputs(2'b00, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0);
        checks++; if (proto_err_o !== 1'b1) begin failures++; $display("[TB] FAIL spur_err: got %b expected 1", proto_err_o); end
        set_inputs(2'b01, 32'h100, 32'h0, 1'b1, 1'b0, 32'h0);
        set_inputs(2'b00, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0);
        checks++; if (proto_err_o !== 1'b1 || outstanding_o !== 2'd1) begin failures++; $display("[TB] FAIL spur_sticky: got %b/%0d expected 1/1", proto_err_o, outstanding_o); end
        rst_ni = 1'b0;
        #1;
        checks++; if (proto_err_o !== 1'b0 || outstanding_o !== 2'd0) begin failures++; $display("[TB] FAIL spur_async_rst: got %b/%0d expected 0/0", proto_err_o, outstanding_o); end
        @(negedge clk_i);
        rst_ni = 1'b1;
        set_inputs(2'b00, 32'h0, 32'h0, 1'b0, 1'b1, 32'hC0);
        checks++; if (rvalid_o !== 2'b00) begin failures++; $display("[TB] FAIL spur_dropped_entry: got %b expected 00", rvalid_o); end
        set_inputs(2'b00, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0);
        checks++; if (proto_err_o !== 1'b1) begin failures++; $display("[TB] FAIL spur_after_rst: got %b expected 1", proto_err_o); end
        do_reset();
        set_inputs(2'b01, 32'h300, 32'h0, 1'b1, 1'b1, 32'hD0);
        checks++; if (gnt_o !== 2'b01 || rvalid_o !== 2'b00) begin failures++; $display("[TB] FAIL same_cycle_gnt_rv: got %b/%b expected 01/00", gnt_o, rvalid_o); end
        set_inputs(2'b00, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0);
        checks++; if (proto_err_o !== 1'b1 || outstanding_o !== 2'd1) begin failures++; $display("[TB] FAIL same_cycle_err: got %b/%0d expected 1/1", proto_err_o, outstanding_o); end
    endtask

    initial begin
        rst_ni       = 1'b0;
        req_i        = '0;
        addr_i       = '0;
        mem_gnt_i    = 1'b0;
        mem_rvalid_i = 1'b0;
        mem_rdata_i  = '0;
        test_reset();
        test_single();
        test_round_robin();
        test_addr_lock();
        test_outstanding_cap();
        test_out_of_order_ids();
        test_spurious_and_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
